// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// master: controller side (takes OpCode/Func/Zero, drives enables, selects and status).
// slave : datapath side (drives OpCode/Func/Zero, takes enables, selects and status).
interface mips_multicycle_controller_if;
  logic [5:0]  OpCode;
  logic [5:0]  Func;
  logic        Zero;
  logic        pc_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        save;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  AluOperation;
  logic [1:0]  pc_src;
  logic        instr_done;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  OpCode, Func, Zero,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, save,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, AluOperation, pc_src,
           instr_done, illegal, retired
  );

  modport slave (
    output OpCode, Func, Zero,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, save,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, AluOperation, pc_src,
           instr_done, illegal, retired
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS core (3-5 cycles per instruction),
// plus a retired-instruction counter. Ports: clk, rst (async, active high) and
// bus (master modport): OpCode/Func/Zero in; datapath enables/selects, instr_done, illegal, retired out.
module mips_multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  mips_multicycle_controller_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXR, S_WBR, S_EXI, S_WBI, S_MADDR,
    S_MRD, S_WBL, S_MWR, S_BR, S_JMP, S_JAL, S_JR
  } state_t;

  state_t      state, next_state;
  logic [31:0] retired_q;
  logic        id_illegal;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= next_state;
  end

  // Next-state logic; ID also flags unsupported opcode/function combinations
  always_comb begin
    next_state = S_IF;
    id_illegal = 1'b0;
    case (state)
      S_IF: next_state = S_ID;
      S_ID: begin
        case (bus.OpCode)
          OP_RTYPE: begin
            case (bus.Func)
              FN_JR:                                   next_state = S_JR;
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:   next_state = S_EXR;
              default:                                 id_illegal = 1'b1;
            endcase
          end
          OP_LW, OP_SW:     next_state = S_MADDR;
          OP_ADDI, OP_SLTI: next_state = S_EXI;
          OP_BEQ, OP_BNE:   next_state = S_BR;
          OP_J:             next_state = S_JMP;
          OP_JAL:           next_state = S_JAL;
          default:          id_illegal = 1'b1;
        endcase
      end
      S_EXR:   next_state = S_WBR;
      S_EXI:   next_state = S_WBI;
      S_MADDR: next_state = (bus.OpCode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   next_state = S_WBL;
      default: next_state = S_IF;
    endcase
  end

  // Output logic; strobes are held low while rst is asserted
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.i_or_d       = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.ir_write     = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.save         = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.reg_write    = 1'b0;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 2'b00;
    bus.AluOperation = 3'b000;
    bus.pc_src       = 2'b00;
    bus.instr_done   = 1'b0;
    bus.illegal      = 1'b0;
    case (state)
      S_IF: begin
        bus.mem_read     = 1'b1;
        bus.ir_write     = 1'b1;
        bus.pc_write     = 1'b1;
        bus.alu_src_b    = 2'b01;
        bus.AluOperation = ALU_ADD;
      end
      S_ID: begin
        // Branch target precomputed into ALUOut while decoding
        bus.alu_src_b    = 2'b11;
        bus.AluOperation = ALU_ADD;
        bus.illegal      = id_illegal;
      end
      S_EXR: begin
        bus.alu_src_a = 1'b1;
        case (bus.Func)
          FN_SUB:  bus.AluOperation = ALU_SUB;
          FN_AND:  bus.AluOperation = ALU_AND;
          FN_OR:   bus.AluOperation = ALU_OR;
          FN_SLT:  bus.AluOperation = ALU_SLT;
          default: bus.AluOperation = ALU_ADD;
        endcase
      end
      S_WBR: begin
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_EXI: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = 2'b10;
        bus.AluOperation = (bus.OpCode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_WBI: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MADDR: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = 2'b10;
        bus.AluOperation = ALU_ADD;
      end
      S_MRD: begin
        bus.i_or_d   = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_WBL: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MWR: begin
        bus.i_or_d     = 1'b1;
        bus.mem_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BR: begin
        // Only input-dependent output: Zero decides whether the branch is taken
        bus.alu_src_a    = 1'b1;
        bus.AluOperation = ALU_SUB;
        bus.pc_src       = 2'b01;
        bus.pc_write     = (bus.OpCode == OP_BNE) ? ~bus.Zero : bus.Zero;
        bus.instr_done   = 1'b1;
      end
      S_JMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from IF, so it is the link value
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b10;
        bus.save       = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JR: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b11;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

  // Retired-instruction counter, wraps modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 retired_q <= 32'd0;
    else if (bus.instr_done) retired_q <= retired_q + 32'd1;
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multi-cycle MIPS controller: walks every instruction
// class cycle by cycle, comparing the full control word and the retired count
// against hand-computed values.
module tb_mips_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Control word: {pc_write,i_or_d,mem_read,mem_write,ir_write,
  //                reg_dst,save,mem_to_reg,reg_write,alu_src_a,
  //                alu_src_b[1:0],AluOperation[2:0],pc_src[1:0],instr_done,illegal}
  logic [18:0] cw;
  assign cw = {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
               bus.reg_dst, bus.save, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
               bus.alu_src_b, bus.AluOperation, bus.pc_src, bus.instr_done, bus.illegal};

  localparam logic [18:0] C_IF      = {5'b10101, 5'b00000, 2'b01, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] C_IFR     = {5'b00000, 5'b00000, 2'b01, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] C_ID      = {5'b00000, 5'b00000, 2'b11, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] C_IDX     = {5'b00000, 5'b00000, 2'b11, 3'b010, 2'b00, 2'b01};
  localparam logic [18:0] C_EXR_ADD = {5'b00000, 5'b00001, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] C_EXR_SLT = {5'b00000, 5'b00001, 2'b00, 3'b111, 2'b00, 2'b00};
  localparam logic [18:0] C_WBR     = {5'b00000, 5'b10010, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] C_EXI_ADD = {5'b00000, 5'b00001, 2'b10, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] C_EXI_SLT = {5'b00000, 5'b00001, 2'b10, 3'b111, 2'b00, 2'b00};
  localparam logic [18:0] C_WBI     = {5'b00000, 5'b00010, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] C_MRD     = {5'b01100, 5'b00000, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] C_WBL     = {5'b00000, 5'b00110, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] C_MWR     = {5'b01010, 5'b00000, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] C_BRT     = {5'b10000, 5'b00001, 2'b00, 3'b110, 2'b01, 2'b10};
  localparam logic [18:0] C_BRF     = {5'b00000, 5'b00001, 2'b00, 3'b110, 2'b01, 2'b10};
  localparam logic [18:0] C_JMP     = {5'b10000, 5'b00000, 2'b00, 3'b000, 2'b10, 2'b10};
  localparam logic [18:0] C_JAL     = {5'b10000, 5'b01010, 2'b00, 3'b000, 2'b10, 2'b10};
  localparam logic [18:0] C_JR      = {5'b10000, 5'b00000, 2'b00, 3'b000, 2'b11, 2'b10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check this cycle's control word, then advance one clock
  task automatic cyc(input string tag, input logic [18:0] exp);
    #1;
    chk(tag, {13'd0, cw}, {13'd0, exp});
    @(negedge clk);
  endtask

  task automatic set_inst(input logic [5:0] op, input logic [5:0] fn);
    bus.OpCode = op;
    bus.Func   = fn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.OpCode = 6'd0;
    bus.Func   = 6'd0;
    bus.Zero   = 1'b0;

    // Power-on reset held over two clocks
    @(negedge clk);
    #1;
    chk("reset_cw", {13'd0, cw}, {13'd0, C_IFR});
    chk("reset_retired", bus.retired, 32'd0);
    @(negedge clk);
    chk("reset_cw_hold", {13'd0, cw}, {13'd0, C_IFR});
    rst = 1'b0;

    // add: 4 cycles
    set_inst(6'b000000, 6'b100000);
    cyc("add_if", C_IF);
    cyc("add_id", C_ID);
    cyc("add_exr", C_EXR_ADD);
    cyc("add_wbr", C_WBR);
    chk("add_retired", bus.retired, 32'd1);

    // slt: ALU op taken from Func
    set_inst(6'b000000, 6'b101010);
    cyc("slt_if", C_IF);
    cyc("slt_id", C_ID);
    cyc("slt_exr", C_EXR_SLT);
    cyc("slt_wbr", C_WBR);
    chk("slt_retired", bus.retired, 32'd2);

    // lw: 5 cycles
    set_inst(6'b100011, 6'b000000);
    cyc("lw_if", C_IF);
    cyc("lw_id", C_ID);
    cyc("lw_maddr", C_EXI_ADD);
    cyc("lw_mrd", C_MRD);
    cyc("lw_wbl", C_WBL);
    chk("lw_retired", bus.retired, 32'd3);

    // sw: 4 cycles
    set_inst(6'b101011, 6'b000000);
    cyc("sw_if", C_IF);
    cyc("sw_id", C_ID);
    cyc("sw_maddr", C_EXI_ADD);
    cyc("sw_mwr", C_MWR);
    chk("sw_retired", bus.retired, 32'd4);

    // addi / slti
    set_inst(6'b001000, 6'b000000);
    cyc("addi_if", C_IF);
    cyc("addi_id", C_ID);
    cyc("addi_exi", C_EXI_ADD);
    cyc("addi_wbi", C_WBI);
    set_inst(6'b001010, 6'b000000);
    cyc("slti_if", C_IF);
    cyc("slti_id", C_ID);
    cyc("slti_exi", C_EXI_SLT);
    cyc("slti_wbi", C_WBI);
    chk("imm_retired", bus.retired, 32'd6);

    // beq: pc_write follows Zero within the BR cycle
    set_inst(6'b000100, 6'b000000);
    cyc("beq_if", C_IF);
    cyc("beq_id", C_ID);
    bus.Zero = 1'b1;
    #1;
    chk("beq_zero1", {13'd0, cw}, {13'd0, C_BRT});
    bus.Zero = 1'b0;
    #1;
    chk("beq_zero0", {13'd0, cw}, {13'd0, C_BRF});
    @(negedge clk);

    // bne: inverse sense
    set_inst(6'b000101, 6'b000000);
    cyc("bne_if", C_IF);
    cyc("bne_id", C_ID);
    bus.Zero = 1'b1;
    #1;
    chk("bne_zero1", {13'd0, cw}, {13'd0, C_BRF});
    bus.Zero = 1'b0;
    #1;
    chk("bne_zero0", {13'd0, cw}, {13'd0, C_BRT});
    @(negedge clk);
    chk("br_retired", bus.retired, 32'd8);

    // Jumps: 3 cycles each
    set_inst(6'b000010, 6'b000000);
    cyc("j_if", C_IF);
    cyc("j_id", C_ID);
    cyc("j_jmp", C_JMP);
    set_inst(6'b000011, 6'b000000);
    cyc("jal_if", C_IF);
    cyc("jal_id", C_ID);
    cyc("jal_jal", C_JAL);
    set_inst(6'b000000, 6'b001000);
    cyc("jr_if", C_IF);
    cyc("jr_id", C_ID);
    cyc("jr_jr", C_JR);
    chk("jump_retired", bus.retired, 32'd11);

    // Illegal opcode, then unsupported R-type function: 2 cycles, no retire
    set_inst(6'b111111, 6'b000000);
    cyc("ill_op_if", C_IF);
    cyc("ill_op_id", C_IDX);
    set_inst(6'b000000, 6'b000000);
    cyc("ill_fn_if", C_IF);
    cyc("ill_fn_id", C_IDX);
    chk("ill_retired", bus.retired, 32'd11);

    // Reset in the middle of a lw (during MRD)
    set_inst(6'b100011, 6'b000000);
    cyc("lwr_if", C_IF);
    cyc("lwr_id", C_ID);
    cyc("lwr_maddr", C_EXI_ADD);
    #1;
    chk("lwr_mrd", {13'd0, cw}, {13'd0, C_MRD});
    rst = 1'b1;
    #1;
    chk("midreset_cw", {13'd0, cw}, {13'd0, C_IFR});
    chk("midreset_retired", bus.retired, 32'd0);
    @(negedge clk);
    chk("midreset_cw_hold", {13'd0, cw}, {13'd0, C_IFR});
    @(negedge clk);
    rst = 1'b0;

    // Counter wrap through one j
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    chk("wrap_preload", bus.retired, 32'hFFFF_FFFF);
    set_inst(6'b000010, 6'b000000);
    cyc("wrap_if", C_IF);
    cyc("wrap_id", C_ID);
    cyc("wrap_jmp", C_JMP);
    chk("wrap_retired", bus.retired, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Moore-style control state machine for the multi-cycle MIPS core, sitting directly in front of the shared-memory datapath. It consumes the opcode, function field and ALU zero flag produced by the datapath and drives every datapath enable and select on each clock. It replaces the single-cycle combinational controller: one instruction takes 3–5 cycles. A retired-instruction counter is included for debug and verification.

## Interface
- No parameters. The encodings below are fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- OpCode  in  6  inst[31:26] from the instruction register. Stable from the end of IF until the next IF.
- Func  in  6  inst[5:0] from the instruction register.
- Zero  in  1  ALU zero flag. Combinational in the current cycle.
- pc_write  out  1  PC load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- save  out  1  forces write register 31 and write data PC (jal).
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- AluOperation  out  3  ALU op code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in ID when the opcode or function field is unsupported.
- retired  out  32  count of completed instructions. Wraps modulo 2^32.

## Operation
- Supported opcodes:
  - R-type 000000, with Func add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, j 000010, jal 000011.
- Outputs not listed for a state are 0.
- State IF:
  - Asserts mem_read, ir_write, pc_write, alu_src_b=01, AluOperation=add, pc_src=00.
  - Next state: ID.
- State ID:
  - Asserts alu_src_b=11, AluOperation=add. This precomputes the branch target into ALUOut.
  - Dispatch by opcode:
    - R-type (not jr) -> EXR. jr -> JR.
    - lw/sw -> MADDR. addi/slti -> EXI.
    - beq/bne -> BR. j -> JMP. jal -> JAL.
    - Anything else -> IF, with illegal pulsed and instr_done not pulsed.
- EXR: alu_src_a=1, alu_src_b=00, AluOperation from Func. Next: WBR.
- WBR: reg_dst=1, reg_write=1, instr_done. Next: IF.
- EXI: alu_src_a=1, alu_src_b=10, AluOperation add (addi) or slt (slti). Next: WBI.
- WBI: reg_dst=0, reg_write=1, instr_done. Next: IF.
- MADDR: alu_src_a=1, alu_src_b=10, add. Next: MRD for lw, MWR for sw.
- MRD: i_or_d=1, mem_read=1. Next: WBL.
- WBL: mem_to_reg=1, reg_write=1, instr_done. Next: IF.
- MWR: i_or_d=1, mem_write=1, instr_done. Next: IF.
- BR:
  - Drives alu_src_a=1, alu_src_b=00, sub, pc_src=01, instr_done.
  - pc_write = Zero for beq, ~Zero for bne. This is the only output that depends on an input (Mealy).
  - Next: IF.
- JMP: pc_write=1, pc_src=10, instr_done. Next: IF.
- JAL: pc_write=1, pc_src=10, save=1, reg_write=1, instr_done. Next: IF. The register write uses the already-incremented PC (PC+4).
- JR: pc_write=1, pc_src=11, instr_done. Next: IF.
- retired increments by 1 on every clock edge where instr_done=1. From 32'hFFFFFFFF it wraps to 0.

## Timing
- Cycles per instruction:
  - R-type, addi, slti, sw: 4.
  - lw: 5.
  - beq, bne, j, jal, jr: 3.
  - Illegal: 2.
- Reset:
  - State goes to IF immediately, with no clock needed; retired = 0.
  - While rst is high, pc_write, ir_write, reg_write, mem_read, mem_write, instr_done and illegal are forced to 0.
  - The first rising edge after rst falls completes IF.
- Reset asserted mid-instruction aborts it: no write strobe occurs after rst rises, and retired is not incremented.
- All state and counter updates happen on the rising edge. Outputs are combinational from the current state, plus Zero in BR.
- Zero must settle within the BR cycle. The controller does not register it.

## Test plan
- Reset: hold rst for 2 cycles while in MRD -> state IF at once, all strobes 0, retired=0. First instruction fetched on the next edge.
- add (OpCode 000000, Func 100000):
  - Sequence is IF, ID, EXR, WBR.
  - WBR has reg_dst=1, reg_write=1, instr_done=1.
  - retired goes 0 -> 1 after 4 edges.
- lw then sw:
  - lw takes 5 cycles, with i_or_d=1 and mem_read=1 in cycle 4 and mem_to_reg=1 in cycle 5.
  - sw takes 4 cycles, with mem_write=1 only in cycle 4.
  - retired=2 after 9 edges.
- Branches:
  - beq with Zero=1 -> pc_write=1, pc_src=01 in BR.
  - beq with Zero=0 -> pc_write=0.
  - bne gives the inverse in both cases. All take 3 cycles.
- Jumps:
  - jal -> JAL cycle with save=1, reg_write=1, pc_src=10.
  - jr (Func 001000) -> pc_src=11, reg_write=0.
- Illegal and wrap:
  - OpCode 111111 -> illegal pulses in ID, next state IF, retired unchanged.
  - Force retired to 32'hFFFFFFFF, complete one j -> retired=0.
